// File: rtl/pulse_detect_mc.sv
// Multi-channel pulse-width detector: per-channel FSM classifies each
// active run as a valid pulse or a width error and counts valid pulses.
module pulse_detect_mc #(
    parameter int CH   = 4,
    parameter int MINW = 1,
    parameter int MAXW = 4,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 polarity,
    input  logic                 clr_cnt,
    input  logic [CH-1:0]        data_in,
    output logic [CH-1:0]        pulse_out,
    output logic [CH-1:0]        width_err,
    output logic [CH*CNTW-1:0]   pulse_cnt
);

    localparam int WW = $clog2(MAXW + 2);
    localparam logic [WW-1:0] W_MAX = WW'(MAXW);
    localparam logic [WW-1:0] W_MIN = WW'(MINW);
    localparam logic [WW-1:0] W_ONE = WW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        OVER
    } state_t;

    logic                pol_q;
    logic                smp_vld;
    logic [CH-1:0]       smp_q;
    logic [CH-1:0]       act;
    logic                flush;
    state_t              st_q [CH];
    state_t              st_d [CH];
    logic [WW-1:0]       w_q  [CH];
    logic [WW-1:0]       w_d  [CH];
    logic [CH-1:0]       pls_d;
    logic [CH-1:0]       err_d;
    logic [CNTW-1:0]     cnt_q [CH];

    // smp_vld keeps the reset value of smp_q from posing as an inactive sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol_q   <= 1'b1;
            smp_vld <= 1'b0;
            smp_q   <= '0;
        end else begin
            pol_q   <= polarity;
            smp_vld <= 1'b1;
            smp_q   <= data_in;
        end
    end

    assign act   = pol_q ? smp_q : ~smp_q;
    assign flush = !en || (polarity != pol_q);

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            st_d[i]  = st_q[i];
            w_d[i]   = w_q[i];
            pls_d[i] = 1'b0;
            err_d[i] = 1'b0;
            if (flush) begin
                st_d[i] = IDLE;
                w_d[i]  = '0;
            end else if (smp_vld) begin
                unique case (st_q[i])
                    IDLE: begin
                        if (!act[i]) st_d[i] = ARMED;
                    end
                    ARMED: begin
                        if (act[i]) begin
                            st_d[i] = ACTIVE;
                            w_d[i]  = W_ONE;
                        end
                    end
                    ACTIVE: begin
                        if (act[i]) begin
                            w_d[i] = w_q[i] + 1'b1;
                            if (w_q[i] == W_MAX) st_d[i] = OVER;
                        end else begin
                            st_d[i] = ARMED;
                            w_d[i]  = '0;
                            if (w_q[i] >= W_MIN) pls_d[i] = 1'b1;
                            else                 err_d[i] = 1'b1;
                        end
                    end
                    OVER: begin
                        if (!act[i]) begin
                            st_d[i]  = ARMED;
                            w_d[i]   = '0;
                            err_d[i] = 1'b1;
                        end
                    end
                    default: st_d[i] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_out <= '0;
            width_err <= '0;
            for (int i = 0; i < CH; i++) begin
                st_q[i]  <= IDLE;
                w_q[i]   <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            pulse_out <= pls_d;
            width_err <= err_d;
            for (int i = 0; i < CH; i++) begin
                st_q[i] <= st_d[i];
                w_q[i]  <= w_d[i];
                if (clr_cnt)
                    cnt_q[i] <= '0;
                else if (pls_d[i] && (cnt_q[i] != '1))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        pulse_cnt = '0;
        for (int i = 0; i < CH; i++)
            pulse_cnt[i*CNTW +: CNTW] = cnt_q[i];
    end

endmodule

// File: tb/tb_pulse_detect_mc.sv
// Bench for pulse_detect_mc: run-length reference model checked every
// cycle on a default instance and a MINW=2/CNTW=2 instance.
module tb_pulse_detect_mc;

    localparam int CH   = 4;
    localparam int MAXW = 4;
    localparam int CW0  = 8;
    localparam int CW1  = 2;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              polarity;
    logic              clr_cnt;
    logic [CH-1:0]     data_in;
    logic [CH-1:0]     po0, we0, po1, we1;
    logic [CH*CW0-1:0] pc0;
    logic [CH*CW1-1:0] pc1;

    pulse_detect_mc #(.CH(CH), .MINW(1), .MAXW(MAXW), .CNTW(CW0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .polarity(polarity),
        .clr_cnt(clr_cnt), .data_in(data_in),
        .pulse_out(po0), .width_err(we0), .pulse_cnt(pc0)
    );

    pulse_detect_mc #(.CH(CH), .MINW(2), .MAXW(MAXW), .CNTW(CW1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .polarity(polarity),
        .clr_cnt(clr_cnt), .data_in(data_in),
        .pulse_out(po1), .width_err(we1), .pulse_cnt(pc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a pulse is a run of active samples that started after
    // an inactive sample seen since the last flush, ended by an inactive one.
    int          minw [2] = '{1, 2};
    int          cmax [2] = '{255, 3};
    bit          primed [2][CH];
    int          runlen [2][CH];
    int          cnt [2][CH];
    bit [CH-1:0] exp_p [2];
    bit [CH-1:0] exp_e [2];
    bit [CH-1:0] samp;
    bit          samp_v;
    bit          pol_reg;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_p[k] = '0;
            exp_e[k] = '0;
            for (int c = 0; c < CH; c++) begin
                primed[k][c] = 1'b0;
                runlen[k][c] = 0;
                cnt[k][c]    = 0;
            end
        end
        samp    = '0;
        samp_v  = 1'b0;
        pol_reg = 1'b1;
    endtask

    task automatic model_step();
        bit flush;
        bit a;
        flush = !en || (polarity != pol_reg);
        for (int k = 0; k < 2; k++) begin
            exp_p[k] = '0;
            exp_e[k] = '0;
            for (int c = 0; c < CH; c++) begin
                if (flush) begin
                    primed[k][c] = 1'b0;
                    runlen[k][c] = 0;
                end else if (samp_v) begin
                    a = pol_reg ? samp[c] : !samp[c];
                    if (a) begin
                        if (primed[k][c]) runlen[k][c]++;
                    end else begin
                        if (primed[k][c] && runlen[k][c] > 0) begin
                            if (runlen[k][c] >= minw[k] && runlen[k][c] <= MAXW)
                                exp_p[k][c] = 1'b1;
                            else
                                exp_e[k][c] = 1'b1;
                        end
                        primed[k][c] = 1'b1;
                        runlen[k][c] = 0;
                    end
                end
                if (clr_cnt)
                    cnt[k][c] = 0;
                else if (exp_p[k][c] && cnt[k][c] < cmax[k])
                    cnt[k][c]++;
            end
        end
        samp    = data_in;
        samp_v  = 1'b1;
        pol_reg = polarity;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    int np [2][CH];
    int ne [2][CH];

    initial begin
        logic [CH*CW0-1:0] ec0;
        logic [CH*CW1-1:0] ec1;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++) begin
                np[k][c] = 0;
                ne[k][c] = 0;
            end
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                ec0[c*CW0 +: CW0] = CW0'(cnt[0][c]);
                ec1[c*CW1 +: CW1] = CW1'(cnt[1][c]);
            end
            chk("u0_pulse", 64'(po0), 64'(exp_p[0]));
            chk("u0_err",   64'(we0), 64'(exp_e[0]));
            chk("u0_cnt",   64'(pc0), 64'(ec0));
            chk("u1_pulse", 64'(po1), 64'(exp_p[1]));
            chk("u1_err",   64'(we1), 64'(exp_e[1]));
            chk("u1_cnt",   64'(pc1), 64'(ec1));
            chk("u0_excl",  64'(po0 & we0), 64'd0);
            for (int c = 0; c < CH; c++) begin
                if (po0[c] === 1'b1) np[0][c]++;
                if (we0[c] === 1'b1) ne[0][c]++;
                if (po1[c] === 1'b1) np[1][c]++;
                if (we1[c] === 1'b1) ne[1][c]++;
            end
        end
    end

    logic [CH-1:0] base;

    task automatic drive(input logic [CH-1:0] d);
        @(negedge clk);
        data_in = d;
    endtask

    task automatic pat(input int ch, input string s);
        logic [CH-1:0] d;
        for (int j = 0; j < s.len(); j++) begin
            d     = base;
            d[ch] = (s[j] == 8'h31);
            drive(d);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int b0, b1;
        rst_n    = 1'b0;
        en       = 1'b1;
        polarity = 1'b1;
        clr_cnt  = 1'b0;
        data_in  = '0;
        base     = '0;

        repeat (6) drive(CH'($urandom));
        #1;
        chk("rst_cnt0", 64'(pc0), 64'd0);
        chk("rst_po0",  64'(po0 | we0), 64'd0);

        // released while ch0 is already active: 1,1,0 gives nothing
        @(negedge clk);
        data_in = 4'b0001;
        rst_n   = 1'b1;
        drive(4'b0001);
        drive(4'b0000);
        settle(3);
        chk("pre_active_p", 64'(np[0][0]), 64'd0);
        chk("pre_active_e", 64'(ne[0][0]), 64'd0);

        pat(0, "010");
        settle(1);
        chk("lat_e1", 64'(po0[0]), 64'd0);
        settle(1);
        chk("lat_e2", 64'(po0[0]), 64'd1);
        settle(1);
        chk("lat_e3", 64'(po0[0]), 64'd0);
        chk("t1_cnt", 64'(pc0), 64'h1);
        chk("t1_u1_err", 64'(ne[1][0]), 64'd1);
        chk("t1_u1_cnt", 64'(pc1), 64'd0);

        pat(1, "0111110");
        settle(3);
        chk("t2_err", 64'(ne[0][1]), 64'd1);
        chk("t2_pls", 64'(np[0][1]), 64'd0);
        chk("t2_cnt", 64'(pc0[15:8]), 64'd0);

        pat(2, "01010");
        settle(3);
        chk("t3_pls", 64'(np[0][2]), 64'd2);
        chk("t3_cnt", 64'(pc0[23:16]), 64'd2);
        chk("t3_u1_err", 64'(ne[1][2]), 64'd2);

        pat(3, "010");
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        settle(2);
        chk("t4_pls", 64'(np[0][3]), 64'd1);
        chk("t4_cnt", 64'(pc0), 64'd0);

        pat(0, "0110110110110110");
        settle(3);
        chk("t5_u1_sat", 64'(pc1[1:0]), 64'd3);
        chk("t5_u0_cnt", 64'(pc0[7:0]), 64'd5);

        b0 = np[0][0];
        @(negedge clk);
        polarity = 1'b0;
        base     = '1;
        data_in  = '1;
        pat(0, "101");
        settle(3);
        chk("t6_lowpulse", 64'(np[0][0] - b0), 64'd1);
        @(negedge clk);
        polarity = 1'b1;
        base     = '0;
        data_in  = '0;
        drive('0);

        b0 = np[0][0];
        b1 = ne[0][0];
        pat(0, "011");
        @(negedge clk);
        en      = 1'b0;
        data_in = '0;
        drive('0);
        @(negedge clk);
        en = 1'b1;
        pat(0, "010");
        settle(3);
        chk("t7_en_p", 64'(np[0][0] - b0), 64'd1);
        chk("t7_en_e", 64'(ne[0][0] - b1), 64'd0);

        b0 = np[0][0];
        b1 = ne[0][0];
        pat(0, "011");
        @(negedge clk);
        polarity = 1'b0;
        data_in  = 4'b0001;
        @(negedge clk);
        polarity = 1'b1;
        data_in  = '0;
        pat(0, "010");
        settle(3);
        chk("t8_pol_p", 64'(np[0][0] - b0), 64'd1);
        chk("t8_pol_e", 64'(ne[0][0] - b1), 64'd0);

        b0 = np[0][0];
        b1 = ne[0][0];
        pat(0, "011");
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        data_in = '0;
        #1;
        chk("t9_rst_cnt", 64'(pc0), 64'd0);
        #2 rst_n = 1'b1;
        pat(0, "010");
        settle(3);
        chk("t9_rst_p", 64'(np[0][0] - b0), 64'd1);
        chk("t9_rst_e", 64'(ne[0][0] - b1), 64'd0);
        chk("t9_cnt",   64'(pc0[7:0]), 64'd1);

        for (int n = 0; n < 3000; n++) begin
            logic [CH-1:0] d;
            @(negedge clk);
            d = data_in;
            for (int c = 0; c < CH; c++)
                if ($urandom_range(2) == 0) d[c] = ~d[c];
            data_in = d;
            if (!en) en = ($urandom_range(3) == 0);
            else     en = ($urandom_range(63) != 0);
            if ($urandom_range(96) == 0) polarity = ~polarity;
            clr_cnt = ($urandom_range(49) == 0);
            if ($urandom_range(699) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        clr_cnt = 1'b0;
        settle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
